// File: rtl/cpu_control.sv
// Multi-cycle control FSM for a small register-file CPU.
// Decodes mv/mvi/add/sub into bus, register and ALU strobes.
module cpu_control (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iRun,
  input  logic [15:0] iDin,
  output logic        oIRin,
  output logic [7:0]  oRin,
  output logic [7:0]  oRout,
  output logic        oDinOut,
  output logic        oGout,
  output logic        oAin,
  output logic        oGin,
  output logic        oAddSub,
  output logic        oDone
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  state_t     state, nxt;
  logic [8:0] ir;
  logic [2:0] op;
  logic [7:0] x_oh;
  logic [7:0] y_oh;
  logic       is_mv, is_mvi, is_alu;
  logic       unused_din;

  assign unused_din = ^iDin[15:9];

  assign op     = ir[8:6];
  assign x_oh   = 8'd1 << ir[5:3];
  assign y_oh   = 8'd1 << ir[2:0];
  assign is_mv  = (op == 3'b000);
  assign is_mvi = (op == 3'b001);
  assign is_alu = (op[2:1] == 2'b01);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= T0;
      ir    <= 9'd0;
    end else begin
      state <= nxt;
      if (state == T0 && iRun)
        ir <= iDin[8:0];
    end
  end

  // Reset gates every strobe so an aborted instruction never writes back.
  always_comb begin
    nxt     = state;
    oIRin   = 1'b0;
    oRin    = 8'd0;
    oRout   = 8'd0;
    oDinOut = 1'b0;
    oGout   = 1'b0;
    oAin    = 1'b0;
    oGin    = 1'b0;
    oAddSub = 1'b0;
    oDone   = 1'b0;
    if (!iRst) begin
      unique case (state)
        T0: begin
          oIRin = iRun;
          if (iRun)
            nxt = T1;
        end
        T1: begin
          unique case (1'b1)
            is_mv: begin
              oRout = y_oh;
              oRin  = x_oh;
              oDone = 1'b1;
              nxt   = T0;
            end
            is_mvi: begin
              oDinOut = 1'b1;
              oRin    = x_oh;
              oDone   = 1'b1;
              nxt     = T0;
            end
            is_alu: begin
              oRout = x_oh;
              oAin  = 1'b1;
              nxt   = T2;
            end
            default: begin
              oDone = 1'b1;
              nxt   = T0;
            end
          endcase
        end
        T2: begin
          oRout   = y_oh;
          oGin    = 1'b1;
          oAddSub = op[0];
          nxt     = T3;
        end
        T3: begin
          oGout = 1'b1;
          oRin  = x_oh;
          oDone = 1'b1;
          nxt   = T0;
        end
        default: nxt = T0;
      endcase
    end
  end

endmodule
